// File: rtl/vector_alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : vector_alu_sequencer_if
// Brief     : Instruction handshake, beat handshake and status bundle between
//             the control unit, the sequencer and the vector ALU/writeback.
// Revision  : 1.0 - initial release
// ============================================================================
interface vector_alu_sequencer_if #(
  parameter int LANES          = 8,
  parameter int LANES_PER_BEAT = 2
);
  localparam int BEATS = LANES / LANES_PER_BEAT;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             alu_op;
  logic [3:0]       funct;
  logic             beat_ready;
  logic             beat_valid;
  logic [IDX_W-1:0] beat_idx;
  logic [LANES-1:0] lane_en;
  logic [2:0]       alu_control;
  logic             src_a;
  logic             busy;
  logic             done;
  logic             illegal;

  // Control unit / ALU side (drives instructions and beat acceptance)
  modport master (
    output flush, in_valid, alu_op, funct, beat_ready,
    input  in_ready, beat_valid, beat_idx, lane_en, alu_control, src_a,
           busy, done, illegal
  );

  // Sequencer side
  modport slave (
    input  flush, in_valid, alu_op, funct, beat_ready,
    output in_ready, beat_valid, beat_idx, lane_en, alu_control, src_a,
           busy, done, illegal
  );
endinterface
`default_nettype wire

// File: rtl/vector_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_alu_sequencer
// Brief    : Decodes one data-processing instruction, holds its ALU control
//            word and walks the vector datapath beat by beat, waiting a
//            per-operation latency before presenting each lane group.
// Revision : 1.0 - initial release
// ============================================================================
module vector_alu_sequencer #(
  parameter int LANES          = 8,
  parameter int LANES_PER_BEAT = 2,
  parameter int MUL_CYCLES     = 2,
  parameter int DIV_CYCLES     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vector_alu_sequencer_if.slave bus
);

  localparam int BEATS   = LANES / LANES_PER_BEAT;
  localparam int IDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);
  localparam logic [LANES-1:0] BEAT_MASK = LANES'({LANES_PER_BEAT{1'b1}});
  localparam logic [2:0]       CTRL_NOP  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [IDX_W-1:0] beat_idx_q, beat_idx_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             src_a_q, src_a_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  logic             in_ready;
  logic [2:0]       dec_ctrl;
  logic             dec_src_a;
  logic [CNT_W-1:0] dec_lat;
  logic             dec_illegal;

  // Instruction decode: control word, operand-A select and per-beat latency
  always_comb begin
    dec_ctrl    = CTRL_NOP;
    dec_src_a   = 1'b0;
    dec_lat     = CNT_W'(1);
    dec_illegal = 1'b0;
    if (bus.alu_op) begin
      // MOV is the one encoding where funct[3] matters
      if (bus.funct == 4'b1010) begin
        dec_ctrl  = 3'b010;
        dec_src_a = 1'b1;
      end else begin
        case (bus.funct[2:0])
          3'b000:  dec_ctrl = 3'b000;
          3'b001:  dec_ctrl = 3'b001;
          3'b011: begin
            dec_ctrl = 3'b011;
            dec_lat  = CNT_W'(MUL_CYCLES);
          end
          3'b100: begin
            dec_ctrl = 3'b100;
            dec_lat  = CNT_W'(DIV_CYCLES);
          end
          3'b101:  dec_ctrl = 3'b101;
          default: dec_illegal = 1'b1;
        endcase
      end
    end
  end

  // Accepting only in IDLE; flush blocks acceptance in the same cycle
  assign in_ready = (state_q == IDLE) && !bus.flush;

  // Next-state, latency counter, beat index and held control word
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    beat_idx_d = beat_idx_q;
    ctrl_d     = ctrl_q;
    src_a_d    = src_a_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    if (bus.flush) begin
      state_d    = IDLE;
      beat_idx_d = '0;
      ctrl_d     = CTRL_NOP;
      src_a_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready) begin
            if (!bus.alu_op) begin
              done_d = 1'b1;
            end else if (dec_illegal) begin
              illegal_d = 1'b1;
            end else begin
              state_d    = EXEC;
              cnt_d      = dec_lat;
              lat_d      = dec_lat;
              beat_idx_d = '0;
              ctrl_d     = dec_ctrl;
              src_a_d    = dec_src_a;
            end
          end
        end
        EXEC: begin
          // The counter holds the remaining execute cycles for this beat
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ISSUE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ISSUE: begin
          if (bus.beat_ready) begin
            if (beat_idx_q == LAST_BEAT) begin
              state_d    = IDLE;
              done_d     = 1'b1;
              beat_idx_d = '0;
              ctrl_d     = CTRL_NOP;
              src_a_d    = 1'b0;
            end else begin
              state_d    = EXEC;
              beat_idx_d = beat_idx_q + IDX_W'(1);
              cnt_d      = lat_q;
            end
          end
        end
        default: begin
          state_d    = IDLE;
          beat_idx_d = '0;
          ctrl_d     = CTRL_NOP;
          src_a_d    = 1'b0;
        end
      endcase
    end
  end

  assign busy_d = (state_d != IDLE);

  // State and registered outputs; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_q      <= '0;
      beat_idx_q <= '0;
      ctrl_q     <= CTRL_NOP;
      src_a_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      beat_idx_q <= beat_idx_d;
      ctrl_q     <= ctrl_d;
      src_a_q    <= src_a_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.beat_valid  = (state_q == ISSUE);
  assign bus.lane_en     = (state_q == ISSUE)
                           ? (BEAT_MASK << (int'(beat_idx_q) * LANES_PER_BEAT))
                           : '0;
  assign bus.beat_idx    = beat_idx_q;
  assign bus.alu_control = ctrl_q;
  assign bus.src_a       = src_a_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;

endmodule
`default_nettype wire
